// File: rtl/apb_req_bridge.sv
// Command FIFO in front of a single-outstanding APB master.
// Four slaves decoded from paddr[31:30]; the response is held until accepted.
module apb_req_bridge #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strb,
  input  logic [2:0]  req_prot,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  psel,
  output logic        penable,
  output logic [31:0] paddr,
  output logic        pwrite,
  output logic [2:0]  pprot,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_t;

  state_t        state_q, state_d;
  cmd_t          mem_q [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          push, pop;

  logic [31:0] paddr_q, paddr_d;
  logic        pwrite_q, pwrite_d;
  logic [2:0]  pprot_q, pprot_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  assign req_ready = (count_q < DEPTH_C);
  assign push      = req_valid && req_ready;
  assign head      = mem_q[rd_ptr_q];

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge pclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{addr: req_addr, write: req_write,
                           wdata: req_wdata, strb: req_strb,
                           prot: req_prot};
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    tmo_d    = tmo_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pprot_d  = pprot_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          state_d  = SETUP;
          paddr_d  = head.addr;
          pwrite_d = head.write;
          pprot_d  = head.prot;
          pwdata_d = head.wdata;
          pstrb_d  = head.write ? head.strb : 4'b0000;
        end
      end
      SETUP: begin
        tmo_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rdata_d = pwrite_q ? 32'h0 : prdata;
          err_d   = pslverr;
          state_d = RESP;
        end else if (tmo_q == TMO_LAST) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tmo_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pprot_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tmo_q    <= tmo_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pprot_q  <= pprot_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    psel = 4'b0000;
    if (state_q == SETUP || state_q == ACCESS) begin
      psel = 4'b0001 << paddr_q[31:30];
    end
  end

  assign penable   = (state_q == ACCESS);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pprot     = pprot_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Directed bench for apb_req_bridge with a small behavioural APB slave.
// Wait states, hang, error and address-keyed read data are set per scenario.
module tb_apb_req_bridge;

  logic        pclk;
  logic        preset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int failures = 0;

  int          ws_cfg = 0;
  logic        hang = 1'b0;
  logic        err_cfg = 1'b0;
  logic        addr_mode = 1'b0;
  logic [31:0] rdata_cfg = 32'h0;
  int          acc_cnt = 0;

  apb_req_bridge #(.DEPTH(4), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pprot(pprot), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(posedge pclk) acc_cnt <= penable ? acc_cnt + 1 : 0;

  assign pready  = !hang && penable && (acc_cnt == ws_cfg);
  assign prdata  = addr_mode ? (paddr ^ 32'h5A5A_5A5A) : rdata_cfg;
  assign pslverr = err_cfg && pready && pwrite;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] p);
    int n;
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    req_strb  = s;
    req_prot  = p;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL push_ready: req_ready=%0b required 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b0;
    #3;
    checks++;
    if ({psel, penable, rsp_valid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctl: psel=%b pen=%b rv=%b required 0",
               psel, penable, rsp_valid);
    end
    checks++;
    if ({paddr, pwdata, pstrb, pprot, pwrite} !== '0) begin
      failures++;
      $display("FAIL reset_bus: paddr=%h pwdata=%h pstrb=%h required 0",
               paddr, pwdata, pstrb);
    end
    checks++;
    if ({rsp_rdata, rsp_err} !== 33'h0) begin
      failures++;
      $display("FAIL reset_rsp: rdata=%h err=%b required 0",
               rsp_rdata, rsp_err);
    end
    tick();
    tick();
    preset = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_single_write();
    ws_cfg = 0;
    push(32'h4000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010);
    checks++;
    if (psel !== 4'b0000 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL wr_k0: psel=%b rv=%b required 0000/0",
               psel, rsp_valid);
    end
    tick();
    checks++;
    if (psel !== 4'b0010 || penable !== 1'b0 || pwrite !== 1'b1) begin
      failures++;
      $display("FAIL wr_setup: psel=%b pen=%b pw=%b required 0010/0/1",
               psel, penable, pwrite);
    end
    checks++;
    if (paddr !== 32'h4000_0010 || pwdata !== 32'hDEAD_BEEF ||
        pstrb !== 4'hF || pprot !== 3'b010) begin
      failures++;
      $display("FAIL wr_bus: paddr=%h pwdata=%h pstrb=%h pprot=%b",
               paddr, pwdata, pstrb, pprot);
    end
    tick();
    checks++;
    if (psel !== 4'b0010 || penable !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL wr_access: psel=%b pen=%b rv=%b required 0010/1/0",
               psel, penable, rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
        psel !== 4'b0000 || penable !== 1'b0) begin
      failures++;
      $display("FAIL wr_resp: rv=%b rdata=%h err=%b psel=%b pen=%b",
               rsp_valid, rsp_rdata, rsp_err, psel, penable);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL wr_hold: rv=%b required 1", rsp_valid);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL wr_done: rv=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_read_wait();
    int sel_cycles;
    int n;
    logic seen;
    ws_cfg    = 3;
    rdata_cfg = 32'h1234_5678;
    push(32'hC000_0004, 1'b0, 32'h5555_AAAA, 4'hF, 3'b001);
    sel_cycles = 0;
    seen = 1'b0;
    n = 0;
    while (!rsp_valid && n < 30) begin
      if (psel === 4'b1000) begin
        sel_cycles++;
        if (!seen) begin
          seen = 1'b1;
          checks++;
          if (pstrb !== 4'h0 || pwrite !== 1'b0 ||
              paddr !== 32'hC000_0004) begin
            failures++;
            $display("FAIL rd_setup: pstrb=%h pw=%b paddr=%h",
                     pstrb, pwrite, paddr);
          end
        end
      end
      tick();
      n++;
    end
    checks++;
    if (sel_cycles != 5) begin
      failures++;
      $display("FAIL rd_psel_cycles: got %0d required 5", sel_cycles);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 ||
        rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL rd_resp: rv=%b rdata=%h err=%b required 1/12345678/0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    ws_cfg = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [5];
    logic [31:0] exp_d [5];
    int got;
    int n;
    addrs = '{32'h0000_0100, 32'h4000_0200, 32'h8000_0300,
              32'hC000_0400, 32'h0000_0500};
    exp_d = '{32'h5A5A_5B5A, 32'h1A5A_585A, 32'hDA5A_595A,
              32'h9A5A_5E5A, 32'h5A5A_5F5A};
    addr_mode = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(addrs[i], 1'b0, 32'h0, 4'h0, 3'b000);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_full: req_ready=%b required 0", req_ready);
    end
    tick();
    tick();
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_stall: req_ready=%b rv=%b required 0/1",
               req_ready, rsp_valid);
    end
    rsp_ready = 1'b1;
    got = 0;
    n = 0;
    while (got < 5 && n < 100) begin
      if (rsp_valid) begin
        checks++;
        if (rsp_rdata !== exp_d[got] || rsp_err !== 1'b0) begin
          failures++;
          $display("FAIL b2b_rsp%0d: rdata=%h err=%b required %h/0",
                   got, rsp_rdata, rsp_err, exp_d[got]);
        end
        got++;
      end
      tick();
      n++;
    end
    checks++;
    if (got != 5) begin
      failures++;
      $display("FAIL b2b_count: got %0d responses required 5", got);
    end
    rsp_ready = 1'b0;
    addr_mode = 1'b0;
  endtask

  task automatic test_timeout();
    int acc;
    int n;
    hang = 1'b1;
    push(32'h8000_0000, 1'b0, 32'h0, 4'h0, 3'b000);
    acc = 0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      if (penable) acc++;
      tick();
      n++;
    end
    checks++;
    if (acc != 16) begin
      failures++;
      $display("FAIL tmo_cycles: got %0d required 16", acc);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 ||
        psel !== 4'b0000) begin
      failures++;
      $display("FAIL tmo_resp: rv=%b err=%b rdata=%h psel=%b",
               rsp_valid, rsp_err, rsp_rdata, psel);
    end
    hang = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_slverr();
    int got;
    int n;
    err_cfg   = 1'b1;
    rdata_cfg = 32'hCAFE_F00D;
    rsp_ready = 1'b1;
    push(32'h4000_0000, 1'b1, 32'h0000_1111, 4'h3, 3'b000);
    push(32'h0000_0008, 1'b0, 32'h0, 4'hF, 3'b000);
    got = 0;
    n = 0;
    while (got < 2 && n < 40) begin
      if (rsp_valid) begin
        checks++;
        if (got == 0 && (rsp_err !== 1'b1 || rsp_rdata !== 32'h0)) begin
          failures++;
          $display("FAIL slverr_wr: err=%b rdata=%h required 1/0",
                   rsp_err, rsp_rdata);
        end
        if (got == 1 && (rsp_err !== 1'b0 ||
                         rsp_rdata !== 32'hCAFE_F00D)) begin
          failures++;
          $display("FAIL slverr_next: err=%b rdata=%h required 0/cafef00d",
                   rsp_err, rsp_rdata);
        end
        got++;
      end
      tick();
      n++;
    end
    checks++;
    if (got != 2) begin
      failures++;
      $display("FAIL slverr_count: got %0d required 2", got);
    end
    rsp_ready = 1'b0;
    err_cfg = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    logic bad;
    hang = 1'b1;
    push(32'h4000_0040, 1'b1, 32'hFFFF_0000, 4'hF, 3'b111);
    push(32'h8000_0080, 1'b1, 32'h0000_FFFF, 4'hF, 3'b111);
    push(32'hC000_00C0, 1'b0, 32'h0, 4'h0, 3'b111);
    n = 0;
    while (!penable && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (penable !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_access: pen=%b required 1", penable);
    end
    preset = 1'b0;
    #1;
    checks++;
    if ({psel, penable, rsp_valid, rsp_err} !== 7'b0 ||
        {paddr, pwdata, pstrb, pprot, pwrite} !== '0 ||
        rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_outs: psel=%b pen=%b paddr=%h pwdata=%h rv=%b",
               psel, penable, paddr, pwdata, rsp_valid);
    end
    tick();
    hang = 1'b0;
    preset = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || psel !== 4'b0000) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL rstmid_quiet: activity after reset release");
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  initial begin
    preset    = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    rsp_ready = 1'b0;
    #2;
    test_reset();
    test_single_write();
    test_read_wait();
    test_back_to_back();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
